// File: rtl/stop_watch_unit.sv
`default_nettype none
// ============================================================================
// Module   : stop_watch_unit
// Purpose  : Stopwatch prescaler, 00:00-59:59 counter and IDLE/RUN/PAUSE control
// Revision : 1.0  initial release
// ============================================================================
module stop_watch_unit #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int PRESC_W       = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stop_watch_en,
  input  logic       mode_button,
  input  logic       inc_button,
  output logic [5:0] stop_watch_minutes,
  output logic [5:0] stop_watch_seconds,
  output logic       stop_watch_ack_flag,
  output logic       stop_watch_running,
  output logic       stop_watch_wrap
);

  localparam logic [PRESC_W-1:0] c_presc_max = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [5:0]         c_max_59    = 6'd59;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_inc_q;
  logic               r_mode_q;
  logic [PRESC_W-1:0] r_presc;
  logic [5:0]         r_min;
  logic [5:0]         r_sec;
  logic               r_armed;
  logic               r_ack;
  logic               r_wrap;

  logic w_inc_rise;
  logic w_mode_rise;
  logic w_count_en;
  logic w_sec_tick;
  logic w_clear;
  logic w_start;
  logic w_armed_nxt;
  logic w_ack_nxt;

  assign w_inc_rise  = inc_button  & ~r_inc_q  & stop_watch_en;
  assign w_mode_rise = mode_button & ~r_mode_q & stop_watch_en;
  assign w_count_en  = (r_state == S_RUN) & stop_watch_en;
  assign w_sec_tick  = w_count_en & (r_presc == c_presc_max);

  // inc_rise is tested first in every state so it wins over mode_rise
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_inc_rise) begin
          w_state_nxt = S_RUN;
          w_start     = 1'b1;
        end
      end
      S_RUN: begin
        if (w_inc_rise || !stop_watch_en) begin
          w_state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (w_inc_rise) begin
          w_state_nxt = S_RUN;
        end else if (w_mode_rise) begin
          w_state_nxt = S_IDLE;
          w_clear     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Armed only after mode_button is seen low while resting in IDLE, so the
  // press that cleared the counters cannot also grant the exit.
  always_comb begin
    w_armed_nxt = r_armed;
    if (w_clear) begin
      w_armed_nxt = 1'b0;
    end else if ((r_state == S_IDLE) && !mode_button) begin
      w_armed_nxt = 1'b1;
    end
  end

  assign w_ack_nxt = (w_state_nxt == S_IDLE) & stop_watch_en & w_armed_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_inc_q  <= 1'b0;
      r_mode_q <= 1'b0;
      r_armed  <= 1'b0;
      r_ack    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_inc_q  <= inc_button;
      r_mode_q <= mode_button;
      r_armed  <= w_armed_nxt;
      r_ack    <= w_ack_nxt;
    end
  end

  // Prescaler is kept across PAUSE so a resumed run finishes the partial second
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_clear || w_start) begin
      r_presc <= '0;
    end else if (w_count_en) begin
      r_presc <= w_sec_tick ? '0 : r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_min  <= 6'd0;
      r_sec  <= 6'd0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_sec_tick & (r_min == c_max_59) & (r_sec == c_max_59);
      if (w_clear) begin
        r_min <= 6'd0;
        r_sec <= 6'd0;
      end else if (w_sec_tick) begin
        if (r_sec == c_max_59) begin
          r_sec <= 6'd0;
          r_min <= (r_min == c_max_59) ? 6'd0 : r_min + 6'd1;
        end else begin
          r_sec <= r_sec + 6'd1;
        end
      end
    end
  end

  assign stop_watch_minutes  = r_min;
  assign stop_watch_seconds  = r_sec;
  assign stop_watch_ack_flag = r_ack;
  assign stop_watch_running  = (r_state == S_RUN);
  assign stop_watch_wrap     = r_wrap;

endmodule
`default_nettype wire

// File: doc/stop_watch_unit.md
Name: stop_watch_unit

Overview:
- Stopwatch datapath and control that produces the elapsed minutes, elapsed seconds and the exit-acknowledge flag used by the clock mode controller while the stopwatch display mode is active.
- Sits directly upstream of the mode controller: it consumes the controller's stopwatch enable plus the shared mode and inc push-buttons, and feeds back the minutes, seconds and acknowledge signals.
- Contains a seconds prescaler, a 00:00–59:59 counter, button edge detectors and an IDLE/RUN/PAUSE state machine.

Parameters:
- TICKS_PER_SEC, 50000000, clk cycles per stopwatch second; minimum 2.
- PRESC_W, 26, prescaler width; must satisfy 2^PRESC_W >= TICKS_PER_SEC.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- stop_watch_en  input  1  high while the mode controller is in stopwatch mode.
- mode_button  input  1  debounced level; the rising edge is used.
- inc_button  input  1  debounced level; the rising edge is the start/pause toggle.
- stop_watch_minutes  output  6  elapsed minutes, binary 0–59.
- stop_watch_seconds  output  6  elapsed seconds, binary 0–59.
- stop_watch_ack_flag  output  1  permits the mode controller to leave stopwatch mode.
- stop_watch_running  output  1  high in RUN.
- stop_watch_wrap  output  1  one-cycle pulse on the 59:59 -> 00:00 rollover.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, minutes=0, seconds=0, prescaler=0.
  - Edge registers=0, ack=0, running=0, wrap=0.
  - Reset mid-count discards everything immediately.
- Edge detect:
  - Each button is registered once.
  - inc_rise = inc_button & ~inc_q & stop_watch_en; mode_rise is formed the same way.
  - Edges that occur while stop_watch_en=0 are ignored.
- State transitions (next clk edge):
  - IDLE: inc_rise -> RUN; the prescaler is cleared to 0.
  - RUN: inc_rise -> PAUSE. stop_watch_en falling -> PAUSE, so counting never continues unseen.
  - PAUSE: inc_rise -> RUN, with the prescaler retained so the fractional second resumes. mode_rise -> IDLE, with minutes, seconds and prescaler cleared.
  - mode_rise in RUN or IDLE has no state effect.
  - If inc_rise and mode_rise occur in the same cycle, inc_rise wins.
- Prescaler:
  - Increments only in RUN with stop_watch_en=1.
  - At TICKS_PER_SEC-1 it returns to 0 and generates a one-cycle sec_tick.
- Counters, on sec_tick:
  - seconds 59 -> 0 and minutes+1; otherwise seconds+1.
  - minutes 59 with seconds 59 -> 00:00, stop_watch_wrap=1 for one cycle, and RUN continues.
  - Counter values never exceed 59.
  - Counters change only on sec_tick or on the PAUSE->IDLE clear.
- Outputs:
  - Minutes and seconds are registered and held while paused or while en=0.
  - They update in the same cycle the counter does (zero extra latency).
  - stop_watch_running = (state==RUN).
- Acknowledge:
  - stop_watch_ack_flag is registered.
  - It is 1 only when state==IDLE, stop_watch_en=1, and mode_button has been sampled low at least once since entering IDLE (an "armed" bit).
  - The armed bit is cleared on every entry to IDLE and on reset.
  - Result: leaving the mode from PAUSE needs two distinct mode presses, one to clear and one to exit, and a held button cannot exit in the same press.
  - ack drops to 0 in the cycle after en falls.

Test Plan (TICKS_PER_SEC=4):
- Reset then idle, en=1, 20 cycles of no buttons -> minutes=0, seconds=0, running=0, ack=1 after mode is sampled low; asserting rst mid-run -> all outputs 0 immediately.
- Start: inc pulse in IDLE, run 4*65 cycles -> seconds=5, minutes=1; inc held high 10 cycles -> exactly one toggle.
- Pause/resume fraction: start, run 6 cycles (seconds=1, prescaler=2), pause for 50 cycles -> no change; resume -> next seconds increment after 2 cycles.
- Wrap: run 3600 s (14400 cycles) from 00:00 -> outputs 00:00, wrap high exactly one cycle, running stays 1.
- Exit handshake: in PAUSE at 03:07, mode press -> 00:00, IDLE, ack=0 while the button is held; after release ack=1; mode press in RUN -> no change and ack=0.
- en drop in RUN at 00:02 -> state=PAUSE, values frozen, ack=0; inc pulses with en=0 ignored; en back high plus inc -> resumes counting.
